// File: rtl/branch_predictor_if.sv
// Fetch/resolve/prediction signal bundle for branch_predictor.
// Bench-side drivers use the master modport; the predictor uses slave.
interface branch_predictor_if #(
   parameter int unsigned INDEX_BITS = 6
);
   logic                  i_FetchValid;
   logic [31:0]           i_FetchPc;
   logic                  o_PredValid;
   logic                  o_PredTaken;
   logic [INDEX_BITS-1:0] o_PredHist;
   logic                  i_ResolveValid;
   logic [31:0]           i_ResolvePc;
   logic                  i_ResolveIsBranch;
   logic                  i_ResolveTaken;
   logic                  i_ResolvePredTaken;
   logic [INDEX_BITS-1:0] i_ResolveHist;
   logic                  o_Mispredict;
   logic                  o_Ready;

   modport master (
      output i_FetchValid, i_FetchPc,
      output i_ResolveValid, i_ResolvePc, i_ResolveIsBranch,
      output i_ResolveTaken, i_ResolvePredTaken, i_ResolveHist,
      input  o_PredValid, o_PredTaken, o_PredHist, o_Mispredict, o_Ready
   );

   modport slave (
      input  i_FetchValid, i_FetchPc,
      input  i_ResolveValid, i_ResolvePc, i_ResolveIsBranch,
      input  i_ResolveTaken, i_ResolvePredTaken, i_ResolveHist,
      output o_PredValid, o_PredTaken, o_PredHist, o_Mispredict, o_Ready
   );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch predictor with an init sweep after reset.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history into the index.
module branch_predictor #(
   parameter int unsigned INDEX_BITS = 6,
   parameter logic [1:0]  INIT_STATE = 2'b01
) (
   input logic               i_Clk,
   input logic               i_Rst_n,
   branch_predictor_if.slave bp
);
   localparam int unsigned ENTRIES = 1 << INDEX_BITS;
   localparam logic [0:0]  ST_INIT = 1'b0;
   localparam logic [0:0]  ST_RUN  = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic [1:0]            cnt_q [ENTRIES];
   logic                  pred_valid_q, pred_taken_q, mispredict_q;
   logic [INDEX_BITS-1:0] pred_hist_q;
   logic [INDEX_BITS-1:0] hist_q, hist_d;
   logic [INDEX_BITS-1:0] fetch_base, resolve_base, fetch_idx, update_idx;
   logic [1:0]            upd_cur, upd_nxt;
   logic                  run, upd_en;

   assign run          = (state_q == ST_RUN);
   assign upd_en       = run & bp.i_ResolveValid & bp.i_ResolveIsBranch;
   assign fetch_base   = bp.i_FetchPc[INDEX_BITS+1:2];
   assign resolve_base = bp.i_ResolvePc[INDEX_BITS+1:2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic unused_pc;
   assign unused_pc  = ^{bp.i_FetchPc[31:INDEX_BITS+2], bp.i_FetchPc[1:0],
                         bp.i_ResolvePc[31:INDEX_BITS+2], bp.i_ResolvePc[1:0]};
   assign fetch_idx  = fetch_base ^ hist_q;
   // Update uses the history captured at prediction time, not the live one.
   assign update_idx = resolve_base ^ bp.i_ResolveHist;
   assign hist_d     = upd_en ? {hist_q[INDEX_BITS-2:0], bp.i_ResolveTaken} : hist_q;
`else
   logic unused_pc;
   assign unused_pc  = ^{bp.i_FetchPc[31:INDEX_BITS+2], bp.i_FetchPc[1:0],
                         bp.i_ResolvePc[31:INDEX_BITS+2], bp.i_ResolvePc[1:0],
                         bp.i_ResolveHist};
   assign fetch_idx  = fetch_base;
   assign update_idx = resolve_base;
   assign hist_d     = '0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_INIT) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == '1) begin
            state_d = ST_RUN;
         end
      end
   end

   always_comb begin
      upd_cur = cnt_q[update_idx];
      upd_nxt = upd_cur;
      if (bp.i_ResolveTaken) begin
         if (upd_cur != 2'b11) upd_nxt = upd_cur + 2'b01;
      end else begin
         if (upd_cur != 2'b00) upd_nxt = upd_cur - 2'b01;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         hist_q       <= '0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_hist_q  <= '0;
         mispredict_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         hist_q       <= hist_d;
         pred_valid_q <= bp.i_FetchValid;
         if (bp.i_FetchValid) begin
            pred_taken_q <= run & cnt_q[fetch_idx][1];
            pred_hist_q  <= hist_q;
         end
         mispredict_q <= bp.i_ResolveValid & bp.i_ResolveIsBranch &
                         (bp.i_ResolveTaken != bp.i_ResolvePredTaken);
      end
   end

   // Counter storage has no reset; the init sweep gives it defined contents.
   always_ff @(posedge i_Clk) begin
      if (i_Rst_n) begin
         if (state_q == ST_INIT) begin
            cnt_q[ptr_q] <= INIT_STATE;
         end else if (upd_en) begin
            cnt_q[update_idx] <= upd_nxt;
         end
      end
   end

   assign bp.o_PredValid  = pred_valid_q;
   assign bp.o_PredTaken  = pred_taken_q;
   assign bp.o_PredHist   = pred_hist_q;
   assign bp.o_Mispredict = mispredict_q;
   assign bp.o_Ready      = run;
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 6, table index width (2^INDEX_BITS entries).
REQ-002 SHALL have parameter INIT_STATE, default 2'b01, counter value written during init (weakly not-taken).
REQ-003 SHALL have port i_Clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_Rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_FetchValid  input  1  prediction request this cycle.
REQ-006 SHALL have port i_FetchPc  input  32  PC of fetched instruction.
REQ-007 SHALL have port o_PredValid  output  1  prediction result valid.
REQ-008 SHALL have port o_PredTaken  output  1  predicted direction.
REQ-009 SHALL have port o_PredHist  output  INDEX_BITS  history snapshot accompanying the prediction.
REQ-010 SHALL have port i_ResolveValid  input  1  M-stage resolution valid.
REQ-011 SHALL have port i_ResolvePc  input  32  PC of resolved instruction.
REQ-012 SHALL have port i_ResolveIsBranch  input  1  resolved instruction is a conditional branch (jumps = 0).
REQ-013 SHALL have port i_ResolveTaken  input  1  actual outcome from the branch unit.
REQ-014 SHALL have port i_ResolvePredTaken  input  1  prediction carried down the pipe for this instruction.
REQ-015 SHALL have port i_ResolveHist  input  INDEX_BITS  o_PredHist carried down the pipe.
REQ-016 SHALL have port o_Mispredict  output  1  registered mispredict pulse.
REQ-017 SHALL have port o_Ready  output  1  table initialised, predictions meaningful.

Function
REQ-018 SHALL hold 2^INDEX_BITS 2-bit saturating counters; bit 1 = predict taken.
REQ-019 SHALL index with PC[INDEX_BITS+1:2] (base index).
REQ-020 SHALL implement FSM INIT -> RUN; INIT writes INIT_STATE to entry 0..2^INDEX_BITS-1, one per cycle, then enters RUN after the last entry is written.
REQ-021 SHALL drive o_Ready = 1 only in RUN.
REQ-022 SHALL respond one cycle after i_FetchValid: o_PredValid = 1 for exactly that cycle, o_PredTaken = counter[1] of the indexed entry; o_PredValid SHALL be 0 in cycles without a request the cycle before.
REQ-023 SHALL return o_PredTaken = 0 for requests accepted in INIT.
REQ-024 SHALL, in RUN, on i_ResolveValid && i_ResolveIsBranch, increment (taken) or decrement (not taken) the entry at the resolve index, saturating at 3 and 0.
REQ-025 SHALL ignore resolutions with i_ResolveIsBranch = 0 for table and history updates.
REQ-026 SHALL ignore table updates in INIT.
REQ-027 SHALL drive o_Mispredict = 1 one cycle after i_ResolveValid && i_ResolveIsBranch && (i_ResolveTaken != i_ResolvePredTaken), in any state; otherwise 0.
REQ-028 SHALL, on same-cycle fetch and update to one index, return the pre-update counter (read-before-write, no bypass).
REQ-029 SHALL accept one fetch and one resolve per cycle with no back-pressure.

Reset
REQ-030 SHALL, while i_Rst_n = 0 at a clock edge, set FSM = INIT, init pointer = 0, o_PredValid = 0, o_PredTaken = 0, o_Mispredict = 0, o_Ready = 0, o_PredHist = 0, history = 0.
REQ-031 SHALL restart the init sweep from entry 0 when reset is asserted mid-sweep or in RUN; table contents before re-init are don't-care.

Configuration
REQ-032 SHALL, with macro BRANCH_PREDICTOR_GSHARE_EN defined, keep an INDEX_BITS global history register shifted left with i_ResolveTaken on each RUN-state branch update, fetch index = base index XOR history, update index = base index XOR i_ResolveHist, o_PredHist = history at request time.
REQ-033 SHALL, without BRANCH_PREDICTOR_GSHARE_EN, use base index for fetch and update, drive o_PredHist = 0 and ignore i_ResolveHist; ports SHALL exist in both builds.

Verification
REQ-034 SHALL cover: reset release, INDEX_BITS=6 -> o_Ready rises exactly 64 cycles later; fetch in cycle 10 -> o_PredValid=1, o_PredTaken=0.
REQ-035 SHALL cover: two taken resolves at PC 0x100 -> fetch PC 0x100 predicts taken; fetch PC 0x104 still predicts 0.
REQ-036 SHALL cover: five taken then one not-taken at PC 0x200 -> counter 3 then 2, prediction stays taken; two more not-taken -> predicts not-taken.
REQ-037 SHALL cover: resolve Taken=1, PredTaken=0, IsBranch=1 -> o_Mispredict pulse 1 cycle later; same with IsBranch=0 -> no pulse, table unchanged.
REQ-038 SHALL cover: same-cycle fetch and taken update at PC 0x300 from state 1 -> returned prediction 0; next fetch returns 1.
REQ-039 SHALL cover: reset asserted at sweep entry 30 -> o_Ready low, sweep restarts at 0, o_Ready high 64 cycles after release; with GSHARE_EN, history 6'b000011 and PC 0x10 -> index 6'b000111.
